// File: rtl/ads5404_pattern_tx.sv
// ads5404_pattern_tx
// Pattern generator that stands in for an ADS5404 converter. Each clock it
// produces two samples per channel (A and B), the per-sample overrange flags
// and the sync markers. These use the same user-side format as the capture path.
//
// Ports:
//   clk, nrst        generator clock, asynchronous active-low reset
//   enable           1 = generate a word this cycle, 0 = bubble and freeze state
//   mode             0 ramp, 1 constant, 2 checkerboard, 3 PRBS15
//   const_a/const_b  constant samples used in mode 1
//   ovr_thresh       unsigned overrange threshold (sample >= thresh sets flag)
//   sync_in          realign request, rising-edge sensitive
//   valid            output word is a generated word
//   da_0/da_1        channel A even/odd sample
//   db_0/db_1        channel B even/odd sample
//   ovra_*/ovrb_*    per-sample overrange flags
//   syncout_0/1      sync marker on even/odd sample (odd is reserved, always 0)
//
// All data and flags go through a SYNC_LATENCY-deep register pipeline. As a
// result, every output comes straight from a flop.
module ads5404_pattern_tx #(
  parameter int NBITS        = 12,
  parameter int SYNC_PERIOD  = 1024,
  parameter int SYNC_LATENCY = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [NBITS-1:0] const_a,
  input  logic [NBITS-1:0] const_b,
  input  logic [NBITS-1:0] ovr_thresh,
  input  logic             sync_in,
  output logic             valid,
  output logic [NBITS-1:0] da_0,
  output logic [NBITS-1:0] da_1,
  output logic [NBITS-1:0] db_0,
  output logic [NBITS-1:0] db_1,
  output logic             ovra_0,
  output logic             ovra_1,
  output logic             ovrb_0,
  output logic             ovrb_1,
  output logic             syncout_0,
  output logic             syncout_1
);

  localparam logic [14:0] LFSR_SEED   = 15'h7FFF;
  localparam bit          PERIOD_EN   = (SYNC_PERIOD > 0);
  localparam logic [31:0] PERIOD_LAST = PERIOD_EN ? 32'(SYNC_PERIOD - 1) : 32'd0;

  // One output word as it travels down the pipeline.
  typedef struct packed {
    logic             vld;
    logic [NBITS-1:0] a0;
    logic [NBITS-1:0] a1;
    logic [NBITS-1:0] b0;
    logic [NBITS-1:0] b1;
    logic             oa0;
    logic             oa1;
    logic             ob0;
    logic             ob1;
    logic             s0;
  } word_t;

  // The even checkerboard sample has bit 0 set, so the pattern is ...0101 (0x555 at 12 bits).
  function automatic logic [NBITS-1:0] chk_pattern();
    logic [NBITS-1:0] p;
    p = '0;
    for (int i = 0; i < NBITS; i++) begin
      p[i] = ((i % 2) == 0);
    end
    return p;
  endfunction

  localparam logic [NBITS-1:0] CHK_EVEN = chk_pattern();

  // x^15 + x^14 + 1: shift left and feed bit14 ^ bit13 into bit 0.
  function automatic logic [14:0] lfsr_step(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  function automatic logic [NBITS-1:0] bit_rev(input logic [NBITS-1:0] x);
    logic [NBITS-1:0] r;
    r = '0;
    for (int i = 0; i < NBITS; i++) begin
      r[i] = x[NBITS-1-i];
    end
    return r;
  endfunction

  logic [NBITS-1:0] cnt_q, cnt_d;
  logic [14:0]      lfsr_q, lfsr_d;
  logic [31:0]      period_q, period_d;
  logic             sync_prev_q;
  word_t            pipe_q [SYNC_LATENCY];

  logic             edge_s;
  logic             realign_s;
  logic             periodic_s;
  logic [NBITS-1:0] base_cnt_s;
  logic [14:0]      base_lfsr_s;
  logic [14:0]      lfsr1_s;
  logic [14:0]      lfsr2_s;
  word_t            gen_d;

  // Next-state generator: build the word for this cycle and advance the active pattern.
  always_comb begin
    edge_s      = sync_in & ~sync_prev_q;
    realign_s   = edge_s & enable;
    // A realigning edge restarts both the ramp and the LFSR, whatever the mode.
    base_cnt_s  = realign_s ? '0 : cnt_q;
    base_lfsr_s = realign_s ? LFSR_SEED : lfsr_q;
    lfsr1_s     = lfsr_step(base_lfsr_s);
    lfsr2_s     = lfsr_step(lfsr1_s);
    periodic_s  = PERIOD_EN && (period_q == PERIOD_LAST);
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    period_d    = period_q;
    gen_d       = '0;
    if (enable) begin
      cnt_d  = base_cnt_s;
      lfsr_d = base_lfsr_s;
      case (mode)
        2'd0: begin
          gen_d.a0 = base_cnt_s;
          gen_d.a1 = base_cnt_s + NBITS'(1);
          gen_d.b0 = ~base_cnt_s;
          gen_d.b1 = ~(base_cnt_s + NBITS'(1));
          cnt_d    = base_cnt_s + NBITS'(2);
        end
        2'd1: begin
          gen_d.a0 = const_a;
          gen_d.a1 = const_a;
          gen_d.b0 = const_b;
          gen_d.b1 = const_b;
        end
        2'd2: begin
          gen_d.a0 = CHK_EVEN;
          gen_d.a1 = ~CHK_EVEN;
          gen_d.b0 = ~CHK_EVEN;
          gen_d.b1 = CHK_EVEN;
        end
        2'd3: begin
          gen_d.a0 = lfsr1_s[NBITS-1:0];
          gen_d.a1 = lfsr2_s[NBITS-1:0];
          gen_d.b0 = bit_rev(lfsr1_s[NBITS-1:0]);
          gen_d.b1 = bit_rev(lfsr2_s[NBITS-1:0]);
          lfsr_d   = lfsr2_s;
        end
        default: begin
          gen_d.a0 = '0;
          gen_d.a1 = '0;
          gen_d.b0 = '0;
          gen_d.b1 = '0;
        end
      endcase
      gen_d.vld = 1'b1;
      gen_d.oa0 = (gen_d.a0 >= ovr_thresh);
      gen_d.oa1 = (gen_d.a1 >= ovr_thresh);
      gen_d.ob0 = (gen_d.b0 >= ovr_thresh);
      gen_d.ob1 = (gen_d.b1 >= ovr_thresh);
      // A realign that coincides with a periodic pulse still gives only one marker.
      gen_d.s0  = realign_s | periodic_s;
      period_d  = (realign_s | periodic_s) ? 32'd0 : period_q + 32'd1;
    end else begin
      gen_d = '0;
    end
  end

  // Generator state, sync_in history and the output pipeline.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      period_q    <= 32'd0;
      sync_prev_q <= 1'b0;
      for (int i = 0; i < SYNC_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      period_q    <= period_d;
      sync_prev_q <= sync_in;
      pipe_q[0]   <= gen_d;
      for (int i = 1; i < SYNC_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign valid     = pipe_q[SYNC_LATENCY-1].vld;
  assign da_0      = pipe_q[SYNC_LATENCY-1].a0;
  assign da_1      = pipe_q[SYNC_LATENCY-1].a1;
  assign db_0      = pipe_q[SYNC_LATENCY-1].b0;
  assign db_1      = pipe_q[SYNC_LATENCY-1].b1;
  assign ovra_0    = pipe_q[SYNC_LATENCY-1].oa0;
  assign ovra_1    = pipe_q[SYNC_LATENCY-1].oa1;
  assign ovrb_0    = pipe_q[SYNC_LATENCY-1].ob0;
  assign ovrb_1    = pipe_q[SYNC_LATENCY-1].ob1;
  assign syncout_0 = pipe_q[SYNC_LATENCY-1].s0;
  assign syncout_1 = 1'b0;

endmodule

// File: tb/tb_ads5404_pattern_tx.sv
module tb_ads5404_pattern_tx;
  localparam int NB = 12;
  localparam int SP = 8;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          nrst;
  logic          enable;
  logic [1:0]    mode;
  logic [NB-1:0] const_a, const_b, ovr_thresh;
  logic          sync_in;
  logic          valid;
  logic [NB-1:0] da_0, da_1, db_0, db_1;
  logic          ovra_0, ovra_1, ovrb_0, ovrb_1, syncout_0, syncout_1;

  always #5 clk = ~clk;

  ads5404_pattern_tx #(.NBITS(NB), .SYNC_PERIOD(SP), .SYNC_LATENCY(SL)) dut (
    .clk(clk), .nrst(nrst), .enable(enable), .mode(mode),
    .const_a(const_a), .const_b(const_b), .ovr_thresh(ovr_thresh), .sync_in(sync_in),
    .valid(valid), .da_0(da_0), .da_1(da_1), .db_0(db_0), .db_1(db_1),
    .ovra_0(ovra_0), .ovra_1(ovra_1), .ovrb_0(ovrb_0), .ovrb_1(ovrb_1),
    .syncout_0(syncout_0), .syncout_1(syncout_1)
  );

  // {valid, a0, a1, b0, b1, oa0, oa1, ob0, ob1, s0, s1}
  typedef logic [54:0] vec_t;

  typedef struct {
    logic [1:0]  md;
    logic [11:0] ca;
    logic [11:0] cb;
    logic [11:0] th;
    logic [51:0] exp_w;   // {a0, a1, b0, b1, oa0, oa1, ob0, ob1}
  } tvec_t;

  vec_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          m_cnt;
  logic [14:0] m_lfsr;
  int          m_per;
  logic        m_prev;
  tvec_t       tab[7];

  function automatic vec_t dut_vec();
    return {valid, da_0, da_1, db_0, db_1, ovra_0, ovra_1, ovrb_0, ovrb_1, syncout_0, syncout_1};
  endfunction

  function automatic logic [14:0] ref_step(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  function automatic logic [11:0] rev12(input logic [11:0] x);
    logic [11:0] r;
    for (int i = 0; i < 12; i++) r[i] = x[11-i];
    return r;
  endfunction

  task automatic check(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_lfsr = 15'h7FFF;
    m_per  = 0;
    m_prev = 1'b0;
    sb.delete();
    for (int i = 0; i < SL - 1; i++) sb.push_back('0);
  endtask

  task automatic model_word(input logic en, input logic [1:0] md, input logic [11:0] ca,
                            input logic [11:0] cb, input logic [11:0] th, input logic si,
                            output vec_t w);
    logic        edge_seen, sync0;
    logic [11:0] a0, a1, b0, b1;
    edge_seen = si && !m_prev;
    m_prev    = si;
    w         = '0;
    if (en) begin
      if (edge_seen) begin
        m_cnt  = 0;
        m_lfsr = 15'h7FFF;
      end
      a0 = '0; a1 = '0; b0 = '0; b1 = '0;
      case (md)
        2'd0: begin
          a0 = 12'(m_cnt); a1 = 12'(m_cnt + 1); b0 = ~a0; b1 = ~a1;
          m_cnt = (m_cnt + 2) % 4096;
        end
        2'd1: begin a0 = ca; a1 = ca; b0 = cb; b1 = cb; end
        2'd2: begin a0 = 12'h555; a1 = 12'hAAA; b0 = 12'hAAA; b1 = 12'h555; end
        default: begin
          m_lfsr = ref_step(m_lfsr); a0 = m_lfsr[11:0];
          m_lfsr = ref_step(m_lfsr); a1 = m_lfsr[11:0];
          b0 = rev12(a0); b1 = rev12(a1);
        end
      endcase
      sync0 = edge_seen || (m_per == SP - 1);
      m_per = sync0 ? 0 : m_per + 1;
      w = {1'b1, a0, a1, b0, b1, a0 >= th, a1 >= th, b0 >= th, b1 >= th, sync0, 1'b0};
    end
  endtask

  // One clock: drive inputs, push the expected word, then compare the oldest expectation.
  task automatic step(input logic en, input logic [1:0] md, input logic [11:0] ca,
                      input logic [11:0] cb, input logic [11:0] th, input logic si,
                      input logic use_tab, input logic [51:0] tab_w, input string name);
    vec_t w, exp_w;
    enable = en; mode = md; const_a = ca; const_b = cb; ovr_thresh = th; sync_in = si;
    model_word(en, md, ca, cb, th, si, w);
    if (use_tab) w[53:2] = tab_w;
    sb.push_back(w);
    @(posedge clk);
    #1;
    exp_w = sb.pop_front();
    check(name, dut_vec(), exp_w);
  endtask

  task automatic run(input int n, input logic en, input logic [1:0] md, input logic si,
                     input string name);
    for (int i = 0; i < n; i++) step(en, md, 12'h123, 12'h456, 12'hF00, si, 1'b0, '0, name);
  endtask

  initial begin
    nrst = 1'b0; enable = 1'b0; mode = 2'd0; const_a = '0; const_b = '0;
    ovr_thresh = '0; sync_in = 1'b0;

    tab[0] = '{2'd1, 12'h800, 12'h7FF, 12'h800, {12'h800, 12'h800, 12'h7FF, 12'h7FF, 4'b1100}};
    tab[1] = '{2'd2, 12'h000, 12'h000, 12'h800, {12'h555, 12'hAAA, 12'hAAA, 12'h555, 4'b0110}};
    tab[2] = '{2'd1, 12'h123, 12'hFFF, 12'h000, {12'h123, 12'h123, 12'hFFF, 12'hFFF, 4'b1111}};
    tab[3] = '{2'd1, 12'h000, 12'h7FE, 12'h7FF, {12'h000, 12'h000, 12'h7FE, 12'h7FE, 4'b0000}};
    tab[4] = '{2'd2, 12'h000, 12'h000, 12'hAAA, {12'h555, 12'hAAA, 12'hAAA, 12'h555, 4'b0110}};
    tab[5] = '{2'd2, 12'h000, 12'h000, 12'hAAB, {12'h555, 12'hAAA, 12'hAAA, 12'h555, 4'b0000}};
    tab[6] = '{2'd1, 12'hFFF, 12'hFFF, 12'hFFF, {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 4'b1111}};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dut_vec(), '0);
    nrst = 1'b1;
    model_reset();

    // Ramp through the 4094/4095 -> 0/1 wrap with periodic sync markers
    run(2060, 1'b1, 2'd0, 1'b0, "ramp_wrap");

    // Single bubble, ramp continues without skipping
    run(1, 1'b0, 2'd0, 1'b0, "bubble");
    run(6, 1'b1, 2'd0, 1'b0, "after_bubble");

    // Realign mid-ramp at cnt=100, then hold sync_in high (no re-trigger)
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    model_reset();
    run(50, 1'b1, 2'd0, 1'b0, "pre_sync");
    run(1, 1'b1, 2'd0, 1'b1, "sync_edge");
    run(6, 1'b1, 2'd0, 1'b0, "post_sync");
    run(10, 1'b1, 2'd0, 1'b1, "sync_hold");
    run(3, 1'b1, 2'd0, 1'b0, "sync_release");
    // Edge while disabled is ignored
    run(1, 1'b0, 2'd0, 1'b0, "dis_low");
    run(1, 1'b0, 2'd0, 1'b1, "dis_edge");
    run(4, 1'b1, 2'd0, 1'b1, "dis_after");
    run(1, 1'b1, 2'd0, 1'b0, "dis_drop");

    // Realign edge coinciding with a periodic pulse
    for (int i = 0; i < SP && m_per != SP - 1; i++) run(1, 1'b1, 2'd0, 1'b0, "to_period");
    run(1, 1'b1, 2'd0, 1'b1, "coincide");
    run(20, 1'b1, 2'd0, 1'b0, "after_coincide");

    // Constant / checkerboard table
    for (int i = 0; i < 7; i++) begin
      step(1'b1, tab[i].md, tab[i].ca, tab[i].cb, tab[i].th, 1'b0, 1'b1, tab[i].exp_w, "table");
    end
    run(4, 1'b1, 2'd0, 1'b0, "table_flush");

    // PRBS15 from reset
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    model_reset();
    run(1000, 1'b1, 2'd3, 1'b0, "prbs");

    // Mid-stream asynchronous reset clears outputs immediately
    #2;
    nrst = 1'b0;
    #1;
    check("async_reset", dut_vec(), '0);
    @(posedge clk);
    #1;
    check("reset_hold", dut_vec(), '0);
    nrst = 1'b1;
    model_reset();
    run(20, 1'b1, 2'd3, 1'b0, "prbs_restart");
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    model_reset();
    run(12, 1'b1, 2'd0, 1'b0, "ramp_restart");
    run(SL, 1'b0, 2'd0, 1'b0, "drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
